// File: rtl/ap_ctrl_drv_pkg.sv
// Shared types and defaults for the ap_ctrl handshake transaction driver.
// Latency statistics are built only when AP_CTRL_DRV_STATS_EN is defined.
package ap_ctrl_drv_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned MAX_OUT_DEF = 4;
  localparam int unsigned LAT_W_DEF   = 32;

  // Reset/clear value for the running minimum; truncated to LAT_W at use.
  localparam logic [63:0] LAT_INIT_MIN = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/ap_ctrl_txn_driver_if.sv
// Command and HLS block-level control handshake bundle.
// master = the driver, slave = the command source / DUT side.
interface ap_ctrl_txn_driver_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             hold_continue;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;

  modport master (
    input  cmd_valid, cmd_count, hold_continue, ap_ready, ap_done,
    output cmd_ready, ap_start, ap_continue
  );

  modport slave (
    output cmd_valid, cmd_count, hold_continue, ap_ready, ap_done,
    input  cmd_ready, ap_start, ap_continue
  );
endinterface

// File: rtl/ap_ctrl_ts_fifo.sv
// Start-timestamp FIFO, one entry per outstanding call; push and pop may coincide.
// The head is visible combinationally so the popping cycle can compute latency.
module ap_ctrl_ts_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_c_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  assign rdata_c_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/ap_ctrl_txn_driver.sv
// Initiator for the ap_start/ap_ready/ap_done/ap_continue handshake: issues a batch
// of calls, bounds outstanding calls and pulses finish when the batch drains.
// Define AP_CTRL_DRV_STATS_EN to build the per-call latency statistics.
module ap_ctrl_txn_driver
  import ap_ctrl_drv_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF,
  parameter int unsigned LAT_W   = LAT_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  ap_ctrl_txn_driver_if.master bus,
  output logic                 busy,
  output logic                 finish,
  output logic [CNT_W-1:0]     started_cnt,
  output logic [CNT_W-1:0]     done_cnt,
  output logic [LAT_W-1:0]     last_latency,
  output logic [LAT_W-1:0]     lat_min,
  output logic [LAT_W-1:0]     lat_max,
  output logic                 proto_err
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] started_q, started_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             ap_start_q, ap_start_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             proto_err_q, proto_err_d;
  logic             cmd_accept, start_hs, done_hs, done_ok;

  assign bus.ap_continue = ~bus.hold_continue;
  assign cmd_accept      = (state_q == ST_IDLE) && bus.cmd_valid;
  assign start_hs        = ap_start_q && bus.ap_ready;
  assign done_hs         = bus.ap_done && bus.ap_continue;
  // A done with nothing outstanding cannot belong to any call, even a same-cycle start.
  assign done_ok         = done_hs && (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    started_d     = started_q;
    done_d        = done_q;
    outstanding_d = outstanding_q;
    proto_err_d   = proto_err_q;
    finish_d      = 1'b0;

    if (start_hs) begin
      remaining_d   = remaining_q - CNT_W'(1);
      started_d     = started_q + CNT_W'(1);
      outstanding_d = outstanding_q + OUT_W'(1);
    end
    if (done_ok) begin
      done_d        = done_q + CNT_W'(1);
      outstanding_d = outstanding_d - OUT_W'(1);
    end else if (done_hs) begin
      proto_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          remaining_d   = bus.cmd_count;
          started_d     = '0;
          done_d        = '0;
          outstanding_d = '0;
          proto_err_d   = 1'b0;
          state_d       = (bus.cmd_count == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (remaining_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding_d == '0) state_d = ST_FIN;
      end
      ST_FIN: begin
        finish_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered start: drops the cycle after the last start or when the window fills.
    ap_start_d  = (state_d == ST_RUN) && (remaining_d != '0) &&
                  (outstanding_d < OUT_W'(MAX_OUT));
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      started_q     <= '0;
      done_q        <= '0;
      outstanding_q <= '0;
      ap_start_q    <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      finish_q      <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      started_q     <= started_d;
      done_q        <= done_d;
      outstanding_q <= outstanding_d;
      ap_start_q    <= ap_start_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      finish_q      <= finish_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign bus.ap_start  = ap_start_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign busy          = busy_q;
  assign finish        = finish_q;
  assign started_cnt   = started_q;
  assign done_cnt      = done_q;
  assign proto_err     = proto_err_q;

`ifdef AP_CTRL_DRV_STATS_EN
  logic [LAT_W-1:0] ts_q, pop_ts, lat_now;
  logic [LAT_W-1:0] last_q, min_q, max_q;

  ap_ctrl_ts_fifo #(
    .DEPTH (MAX_OUT),
    .W     (LAT_W)
  ) u_ts_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (start_hs),
    .wdata_i   (ts_q),
    .pop_i     (done_ok),
    .rdata_c_o (pop_ts)
  );

  // Modular difference keeps latency exact across timestamp wrap.
  assign lat_now = ts_q - pop_ts;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q   <= '0;
      last_q <= '0;
      min_q  <= LAT_W'(LAT_INIT_MIN);
      max_q  <= '0;
    end else begin
      ts_q <= ts_q + LAT_W'(1);
      if (cmd_accept) begin
        last_q <= '0;
        min_q  <= LAT_W'(LAT_INIT_MIN);
        max_q  <= '0;
      end else if (done_ok) begin
        last_q <= lat_now;
        if (lat_now < min_q) min_q <= lat_now;
        if (lat_now > max_q) max_q <= lat_now;
      end
    end
  end

  assign last_latency = last_q;
  assign lat_min      = min_q;
  assign lat_max      = max_q;
`else
  logic unused_accept;
  assign unused_accept = cmd_accept;
  assign last_latency  = '0;
  assign lat_min       = '0;
  assign lat_max       = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_txn_driver.sv
// Directed bench: a serial DUT on a MAX_OUT=1 driver and a pipelined DUT model on a
// MAX_OUT=4 driver; latency expectations collapse to 0 without AP_CTRL_DRV_STATS_EN.
module tb_ap_ctrl_txn_driver;

`ifdef AP_CTRL_DRV_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ap_ctrl_txn_driver_if #(.CNT_W(16)) if_a ();
  ap_ctrl_txn_driver_if #(.CNT_W(16)) if_b ();

  logic        busy_a, finish_a, perr_a, busy_b, finish_b, perr_b;
  logic [15:0] started_a, done_a, started_b, done_b;
  logic [31:0] last_a, min_a, max_a, last_b, min_b, max_b;
  logic        mdone_a, mdone_b, force_done_b;
  int          lat_b;

  ap_ctrl_txn_driver #(.CNT_W(16), .MAX_OUT(1), .LAT_W(32)) u_dut_a (
    .clock(clock), .reset(reset), .bus(if_a.master), .busy(busy_a), .finish(finish_a),
    .started_cnt(started_a), .done_cnt(done_a), .last_latency(last_a),
    .lat_min(min_a), .lat_max(max_a), .proto_err(perr_a)
  );

  ap_ctrl_txn_driver #(.CNT_W(16), .MAX_OUT(4), .LAT_W(32)) u_dut_b (
    .clock(clock), .reset(reset), .bus(if_b.master), .busy(busy_b), .finish(finish_b),
    .started_cnt(started_b), .done_cnt(done_b), .last_latency(last_b),
    .lat_min(min_b), .lat_max(max_b), .proto_err(perr_b)
  );

  assign if_a.ap_done = mdone_a;
  assign if_b.ap_done = mdone_b | force_done_b;

  always @(posedge clock) cyc <= cyc + 1;

  // DUT models: each accepted call completes a fixed latency later; done held until continue.
  int q_a[$];
  int q_b[$];
  always @(posedge clock) begin
    if (reset) begin
      q_a.delete();
      mdone_a <= 1'b0;
    end else begin
      if (mdone_a && if_a.ap_continue && q_a.size() > 0) void'(q_a.pop_front());
      if (if_a.ap_start && if_a.ap_ready) q_a.push_back(cyc + 5);
      mdone_a <= (q_a.size() > 0) && (q_a[0] <= cyc + 1);
    end
  end
  always @(posedge clock) begin
    if (reset) begin
      q_b.delete();
      mdone_b <= 1'b0;
    end else begin
      if (mdone_b && if_b.ap_continue && q_b.size() > 0) void'(q_b.pop_front());
      if (if_b.ap_start && if_b.ap_ready) q_b.push_back(cyc + lat_b);
      mdone_b <= (q_b.size() > 0) && (q_b[0] <= cyc + 1);
    end
  end

  int fin_a = 0, fin_b = 0, ob = 0, ob_max = 0;
  always @(posedge clock) begin
    if (finish_a) fin_a++;
    if (finish_b) fin_b++;
    if (reset) ob = 0;
    else begin
      if (if_b.ap_start && if_b.ap_ready) ob++;
      if (if_b.ap_done && if_b.ap_continue && ob > 0) ob--;
      if (ob > ob_max) ob_max = ob;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lat_exp(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic issue_b(input int count);
    if_b.cmd_count = 16'(count);
    if_b.cmd_valid = 1'b1;
    @(posedge clock); #1;
    if_b.cmd_valid = 1'b0;
  endtask

  initial begin
    int  k;
    bit  seen;
    reset = 1'b1;
    if_a.cmd_valid = 1'b0; if_a.cmd_count = '0; if_a.hold_continue = 1'b0; if_a.ap_ready = 1'b1;
    if_b.cmd_valid = 1'b0; if_b.cmd_count = '0; if_b.hold_continue = 1'b0; if_b.ap_ready = 1'b1;
    force_done_b = 1'b0;
    lat_b = 8;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_ap_start", if_b.ap_start, 0);
    check("rst_cmd_ready", if_b.cmd_ready, 1);
    check("rst_busy", busy_b, 0);
    check("rst_finish", finish_b, 0);
    check("rst_started", started_b, 0);
    check("rst_lat_min", min_b, STATS ? 64'hFFFF_FFFF : 64'd0);
    check("rst_proto_err", perr_b, 0);
    if_b.hold_continue = 1'b1; #1;
    check("continue_low", if_b.ap_continue, 0);
    if_b.hold_continue = 1'b0; #1;
    check("continue_high", if_b.ap_continue, 1);

    // Serial DUT, MAX_OUT=1, latency 5, three calls
    @(posedge clock); #1;
    if_a.cmd_count = 16'd3; if_a.cmd_valid = 1'b1;
    @(posedge clock); #1;
    if_a.cmd_valid = 1'b0;
    check("a_busy", busy_a, 1);
    check("a_cmd_ready", if_a.cmd_ready, 0);
    check("a_start_after_accept", if_a.ap_start, 1);
    seen = 1'b0; k = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1; k++;
      if (finish_a) begin seen = 1'b1; break; end
    end
    check("a_finish_seen", seen, 1);
    check("a_finish_cycle", 64'(k), 19);
    check("a_started", started_a, 3);
    check("a_done", done_a, 3);
    check("a_last_lat", last_a, lat_exp(5));
    check("a_lat_min", min_a, lat_exp(5));
    check("a_lat_max", max_a, lat_exp(5));
    @(posedge clock); #1;
    check("a_finish_pulse", finish_a, 0);
    check("a_fin_count", 64'(fin_a), 1);

    // Pipelined DUT, II=1, latency 8, MAX_OUT=4, ten calls
    lat_b = 8;
    issue_b(10);
    repeat (4) @(posedge clock); #1;
    check("b_stall_start", if_b.ap_start, 0);
    check("b_stall_started", started_b, 4);
    repeat (5) @(posedge clock); #1;
    check("b_first_done", done_b, 1);
    check("b_restart", if_b.ap_start, 1);
    seen = 1'b0; k = 9;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; k++;
      if (finish_b) begin seen = 1'b1; break; end
    end
    check("b_finish_seen", seen, 1);
    check("b_finish_cycle", 64'(k), 29);
    check("b_started", started_b, 10);
    check("b_done", done_b, 10);
    check("b_lat_min", min_b, lat_exp(8));
    check("b_lat_max", max_b, lat_exp(8));
    check("b_max_outstanding", 64'(ob_max), 4);
    @(posedge clock); #1;
    check("b_fin_count", 64'(fin_b), 1);

    // Continue backpressure: latency 2 plus a 6-cycle stall
    lat_b = 2;
    if_b.hold_continue = 1'b1;
    issue_b(1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (if_b.ap_done) begin seen = 1'b1; break; end
    end
    check("hold_done_seen", seen, 1);
    repeat (6) @(posedge clock); #1;
    check("hold_no_done", done_b, 0);
    check("hold_started", started_b, 1);
    check("hold_busy", busy_b, 1);
    if_b.hold_continue = 1'b0;
    @(posedge clock); #1;
    check("release_done", done_b, 1);
    check("release_lat", last_b, lat_exp(8));
    @(posedge clock); #1;
    check("release_finish", finish_b, 1);

    // Spurious done while idle
    @(posedge clock); #1;
    force_done_b = 1'b1;
    @(posedge clock); #1;
    force_done_b = 1'b0;
    check("spur_proto_err", perr_b, 1);
    check("spur_done_cnt", done_b, 1);
    @(posedge clock); #1;
    check("spur_sticky", perr_b, 1);

    // Zero-length batch clears proto_err; finish two cycles after accept
    issue_b(0);
    check("zero_proto_clr", perr_b, 0);
    check("zero_done_clr", done_b, 0);
    check("zero_finish_early", finish_b, 0);
    check("zero_no_start1", if_b.ap_start, 0);
    @(posedge clock); #1;
    check("zero_finish", finish_b, 1);
    check("zero_no_start2", if_b.ap_start, 0);
    @(posedge clock); #1;
    check("zero_finish_off", finish_b, 0);
    check("zero_cmd_ready", if_b.cmd_ready, 1);

    // Reset mid-RUN with two calls outstanding
    lat_b = 8;
    issue_b(5);
    repeat (2) @(posedge clock); #1;
    check("mid_started", started_b, 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_start", if_b.ap_start, 0);
    check("mid_rst_busy", busy_b, 0);
    check("mid_rst_started", started_b, 0);
    check("mid_rst_done", done_b, 0);
    check("mid_rst_cmd_ready", if_b.cmd_ready, 1);
    repeat (15) @(posedge clock); #1;
    check("mid_rst_no_finish", 64'(fin_b), 3);
    check("mid_rst_quiet", started_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
